// File: rtl/plic_gateway.sv
`default_nettype none
// ============================================================================
// Module   : plic_gateway
// Brief    : Per-source PLIC interrupt gateway (level/edge, claim/complete)
// Revision : 1.0 - initial release
// ============================================================================
module plic_gateway #(
    parameter int MAX_PENDING_COUNT = 16,
    parameter int PENDING_CNT_BITS  = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        src_i,
    input  logic                        edge_lvl_i,
    input  logic                        claim_i,
    input  logic                        complete_i,
    output logic                        ip_o,
    output logic                        busy_o,
    output logic [PENDING_CNT_BITS-1:0] pending_cnt_o
);

    localparam logic [PENDING_CNT_BITS-1:0] c_MAX_CNT = PENDING_CNT_BITS'(MAX_PENDING_COUNT);
    localparam logic [PENDING_CNT_BITS-1:0] c_ONE     = PENDING_CNT_BITS'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_CLAIMED = 2'd2
    } state_t;

    state_t                      r_state;
    logic                        r_src_dly;
    logic                        r_ip;
    logic                        r_busy;
    logic [PENDING_CNT_BITS-1:0] r_cnt;

    logic w_rise;
    logic w_cnt_zero;
    logic w_trig;
    logic w_fwd;
    logic w_inc;
    logic w_dec;

    assign w_rise     = src_i & ~r_src_dly;
    assign w_cnt_zero = (r_cnt == '0);
    assign w_trig     = edge_lvl_i ? (~w_cnt_zero | w_rise) : src_i;
    assign w_fwd      = (r_state == ST_IDLE) & w_trig;
    assign w_dec      = w_fwd & ~w_cnt_zero;
    // A fresh edge forwarded with an empty queue is consumed directly; a
    // simultaneous forward frees a slot, so a full queue still absorbs the edge.
    assign w_inc      = w_rise & ~(w_fwd & w_cnt_zero) & ((r_cnt < c_MAX_CNT) | w_dec);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_src_dly <= 1'b0;
            r_ip      <= 1'b0;
            r_busy    <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_src_dly <= src_i;

            case (r_state)
                ST_IDLE: begin
                    if (w_trig) begin
                        r_state <= ST_PENDING;
                        r_ip    <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                ST_PENDING: begin
                    if (claim_i) begin
                        r_state <= ST_CLAIMED;
                        r_ip    <= 1'b0;
                    end
                end
                ST_CLAIMED: begin
                    if (complete_i) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ip    <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase

            if (!edge_lvl_i) begin
                r_cnt <= '0;
            end else if (w_inc && !w_dec) begin
                r_cnt <= r_cnt + c_ONE;
            end else if (w_dec && !w_inc) begin
                r_cnt <= r_cnt - c_ONE;
            end
        end
    end

    assign ip_o          = r_ip;
    assign busy_o        = r_busy;
    assign pending_cnt_o = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_plic_gateway.sv
`default_nettype none
// ============================================================================
// Module   : tb_plic_gateway
// Brief    : Directed testbench with cycle-level reference model for plic_gateway
// Revision : 1.0 - initial release
// ============================================================================
module tb_plic_gateway;

    localparam int MAXC = 4;
    localparam int CB   = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          src_i;
    logic          edge_lvl_i;
    logic          claim_i;
    logic          complete_i;
    logic          ip_o;
    logic          busy_o;
    logic [CB-1:0] pending_cnt_o;

    plic_gateway #(
        .MAX_PENDING_COUNT (MAXC),
        .PENDING_CNT_BITS  (CB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .src_i         (src_i),
        .edge_lvl_i    (edge_lvl_i),
        .claim_i       (claim_i),
        .complete_i    (complete_i),
        .ip_o          (ip_o),
        .busy_o        (busy_o),
        .pending_cnt_o (pending_cnt_o)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miss    = 0;
    int ip_rises = 0;

    // Reference model: request outstanding / claimed flags and an integer queue depth
    bit m_valid = 0;
    bit m_req   = 0;
    bit m_busy  = 0;
    int m_cnt   = 0;
    bit m_prev  = 0;
    bit prev_ip = 0;

    always @(posedge clk) begin
        bit rise, want, fwd, consumed;
        if (rst) begin
            m_req = 0; m_busy = 0; m_cnt = 0; m_prev = 0; m_valid = 1;
        end else if (m_valid) begin
            rise = src_i && !m_prev;
            want = edge_lvl_i ? (m_cnt > 0 || rise) : src_i;
            fwd  = !m_busy && want;
            consumed = fwd && (m_cnt == 0);
            if (fwd) begin
                m_req = 1; m_busy = 1;
            end else if (m_req && claim_i) begin
                m_req = 0;
            end else if (m_busy && !m_req && complete_i) begin
                m_busy = 0;
            end
            if (!edge_lvl_i) begin
                m_cnt = 0;
            end else begin
                if (fwd && m_cnt > 0) m_cnt = m_cnt - 1;
                if (rise && !consumed && m_cnt < MAXC) m_cnt = m_cnt + 1;
            end
            m_prev = src_i;
        end
        #1;
        if (m_valid) begin
            vectors++;
            if (ip_o !== m_req || busy_o !== m_busy || int'(pending_cnt_o) != m_cnt) begin
                miss++;
                $display("FAIL model t=%0t ip=%b/%b busy=%b/%b cnt=%0d/%0d (dut/expected)",
                         $time, ip_o, m_req, busy_o, m_busy, pending_cnt_o, m_cnt);
            end
            if (ip_o === 1'b1 && !prev_ip) ip_rises++;
            prev_ip = (ip_o === 1'b1);
        end
    end

    task automatic pin(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miss++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_claim();
        claim_i = 1; cyc(1); claim_i = 0;
    endtask

    task automatic pulse_complete();
        complete_i = 1; cyc(1); complete_i = 0;
    endtask

    task automatic edge_pulse();
        src_i = 1; cyc(1); src_i = 0; cyc(1);
    endtask

    initial begin
        rst = 1; src_i = 0; edge_lvl_i = 0; claim_i = 0; complete_i = 0;
        cyc(2);
        pin("reset_ip", ip_o, 0);
        pin("reset_busy", busy_o, 0);
        pin("reset_cnt", pending_cnt_o, 0);

        // Level basic
        rst = 0; src_i = 1;
        cyc(1); pin("lvl_ip_raise", ip_o, 1); pin("lvl_busy", busy_o, 1);
        pulse_claim(); pin("lvl_claim_ip", ip_o, 0); pin("lvl_claim_busy", busy_o, 1);
        pulse_complete(); pin("lvl_done_busy", busy_o, 0);
        cyc(1); pin("lvl_reraise", ip_o, 1);

        // claim+complete together in PENDING: only the claim is taken
        claim_i = 1; complete_i = 1; cyc(1); claim_i = 0; complete_i = 0;
        pin("both_ip", ip_o, 0); pin("both_busy", busy_o, 1);
        src_i = 0; pulse_complete(); cyc(2);
        pin("lvl_low_idle", ip_o, 0);

        // Level drop while pending
        src_i = 1; cyc(1); src_i = 0;
        pin("drop_ip", ip_o, 1);
        cyc(3); pin("drop_hold", ip_o, 1);
        pulse_claim(); pulse_complete(); cyc(2);
        pin("drop_after", ip_o, 0); pin("drop_busy", busy_o, 0);
        pulse_complete(); pin("idle_complete", busy_o, 0);

        // Edge queueing
        edge_lvl_i = 1; cyc(2);
        ip_rises = 0;
        edge_pulse(); edge_pulse(); edge_pulse();
        pin("q_cnt2", pending_cnt_o, 2); pin("q_ip", ip_o, 1);
        for (int i = 0; i < 3; i++) begin
            pulse_claim(); pulse_complete(); cyc(1);
        end
        cyc(3);
        pin("q_rises", ip_rises, 3); pin("q_cnt0", pending_cnt_o, 0);

        // Simultaneous rise with forward at cnt=2
        edge_pulse(); pulse_claim(); edge_pulse(); edge_pulse();
        pin("sim_cnt_pre", pending_cnt_o, 2);
        complete_i = 1; cyc(1); complete_i = 0; src_i = 1; cyc(1);
        pin("sim_cnt", pending_cnt_o, 2); pin("sim_ip", ip_o, 1);
        src_i = 0; cyc(1);

        // Saturation while CLAIMED
        pulse_claim();
        for (int i = 0; i < 10; i++) edge_pulse();
        pin("sat_cnt", pending_cnt_o, MAXC);
        ip_rises = 0;
        for (int i = 0; i < MAXC; i++) begin
            pulse_complete(); cyc(1); pulse_claim();
        end
        pin("sat_cnt0", pending_cnt_o, 0);

        // Reset mid-operation from CLAIMED with cnt=3
        edge_pulse(); edge_pulse(); edge_pulse();
        pin("rst_pre_cnt", pending_cnt_o, 3);
        rst = 1; src_i = 1; cyc(1); rst = 0;
        pin("rst_ip", ip_o, 0); pin("rst_busy", busy_o, 0); pin("rst_cnt", pending_cnt_o, 0);
        cyc(1); pin("rst_edge_ip", ip_o, 1);
        pin("sat_rises", ip_rises, MAXC + 1);
        src_i = 0;

        // Edge->level switch clears a queued count
        pulse_claim(); edge_pulse(); edge_pulse();
        pin("sw_pre", pending_cnt_o, 2);
        edge_lvl_i = 0; cyc(1);
        pin("sw_cnt", pending_cnt_o, 0); pin("sw_busy", busy_o, 1);
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
        $finish;
    end

endmodule
`default_nettype wire
